instr_decode: RTL and testbench
===============================

// Module: instr_decode
// PURPOSE
//  Instruction decoder for the accumulator CPU.
//  - Turns the 8-bit instruction register IR into datapath controls for the A/B register
//    input muxes, A/B load enables, the 1-bit ALU op, and halt.
//  - Sits between the IR and the register/ALU datapath.
//  - Purely combinational: it holds no state.
// PARAMETERS
//  none (8-bit instruction encoding is fixed)
// PORTS
//  clk    in   1  system clock, rising edge; no state in this block is clocked by it
//  clr    in   1  synchronous active-high clear; no state in this block is cleared by it
//  IR     in   8  current instruction (IR is cleared elsewhere, not by this block)
//  halt   out  1  1 = HALT instruction present
//  op     out  1  ALU operation: 1 = ADD, 0 = SUB; 0 for non-ALU instructions
//  selA   out  1  A mux select: 1 = A takes write bus (immediate or ALU result)
//  loadA  out  1  A register load enable
//  selB   out  1  B mux select: 1 = B takes A, 0 = B takes immediate
//  loadB  out  1  B register load enable
// BEHAVIOUR
//  Interface:
//  - One clock; reset is synchronous and active-high: clk, clr.
//  - The block contains no state, so clr has no effect on the outputs.
//  Timing:
//  - All outputs are combinational functions of IR only.
//  - Zero-cycle latency; outputs settle within one gate delay path of an IR change.
//  - There are no registered outputs and no reset values; after IR is cleared to 0x00,
//    the outputs are those of LDA 0.
//  Encoding (class = IR[7:6]):
//  - 00iiiiii LDA imm : selA=1 loadA=1 selB=0 loadB=0 op=0 halt=0
//  - 01iiiiii LDB imm : selA=0 loadA=0 selB=0 loadB=1 op=0 halt=0
//  - 10xxxoxx ALU     : A <= A op B; selA=1 loadA=1 selB=0 loadB=0 op=IR[2] halt=0
//                       0x84 = ADD A,B (op=1); 0x80 = SUB A,B (op=0)
//  - 11000000 MOV B,A : selB=1 loadB=1, all others 0
//  - 11111111 HALT    : halt=1, all others 0
//  - any other 11xxxxxx : NOP, all outputs 0
//  Invariants:
//  - halt is never asserted together with any load.
//  - loadA and loadB are never both 1.
//  - op=1 only for the ALU class with IR[2]=1.
//  - Any X/Z on IR[7:6] yields all outputs 0 in simulation (default branch).
// TESTING
//  IR=0xFF -> halt=1, loadA=0, loadB=0 within 5 ns.
//  IR=0xFF then IR=0x00, clr pulsed 5 ns -> halt=0 within 5 ns of IR change.
//  IR=0x05 (LDA 5) -> selA=1 loadA=1 selB=0 loadB=0.
//  IR=0x6B (LDB 43) -> selA=0 loadA=0 selB=0 loadB=1.
//  IR=0x84 (ADD A,B) -> selA=1 loadA=1 selB=0 loadB=0 op=1; IR=0x80 -> op=0, same loads.
//  IR=0xC0 (MOV B,A) -> selB=1 loadB=1 loadA=0 halt=0; IR=0xC5 -> all outputs 0.

Source files
------------

// File: rtl/instr_decode.sv
// Instruction decoder for the accumulator CPU: maps the 8-bit IR onto A/B mux selects,
// load enables, the 1-bit ALU op and halt. Purely combinational.
module instr_decode (
   input  logic       clk,
   input  logic       clr,
   input  logic [7:0] IR,
   output logic       halt,
   output logic       op,
   output logic       selA,
   output logic       loadA,
   output logic       selB,
   output logic       loadB
);

   localparam logic [1:0] CLS_LDA = 2'b00;
   localparam logic [1:0] CLS_LDB = 2'b01;
   localparam logic [1:0] CLS_ALU = 2'b10;
   localparam logic [1:0] CLS_SYS = 2'b11;

   localparam logic [7:0] IR_MOV  = 8'hC0;
   localparam logic [7:0] IR_HALT = 8'hFF;

   // clk/clr belong to the CPU-wide interface; nothing in here is clocked or cleared.
   logic unused_clk_clr;
   assign unused_clk_clr = clk ^ clr;

   always_comb begin
      halt  = 1'b0;
      op    = 1'b0;
      selA  = 1'b0;
      loadA = 1'b0;
      selB  = 1'b0;
      loadB = 1'b0;
      case (IR[7:6])
         CLS_LDA: begin
            selA  = 1'b1;
            loadA = 1'b1;
         end
         CLS_LDB: begin
            loadB = 1'b1;
         end
         CLS_ALU: begin
            selA  = 1'b1;
            loadA = 1'b1;
            op    = IR[2];
         end
         CLS_SYS: begin
            // Only two encodings are defined in this class; everything else is a NOP.
            if (IR == IR_MOV) begin
               selB  = 1'b1;
               loadB = 1'b1;
            end else if (IR == IR_HALT) begin
               halt = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed encodings, clear-after-halt, and a
// full sweep of all 256 IR values against a reference model through a scoreboard queue.
module tb_instr_decode;

   logic       clk;
   logic       clr;
   logic [7:0] IR;
   logic       halt, op, selA, loadA, selB, loadB;

   int n_checks;
   int n_errors;

   // Expected control vectors, ordered {halt, op, selA, loadA, selB, loadB}.
   logic [5:0] exp_q[$];

   instr_decode dut (
      .clk   (clk),
      .clr   (clr),
      .IR    (IR),
      .halt  (halt),
      .op    (op),
      .selA  (selA),
      .loadA (loadA),
      .selB  (selB),
      .loadB (loadB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [5:0] ref_ctl(input logic [7:0] ir);
      logic [5:0] r;
      r = 6'b000000;
      if (ir[7:6] == 2'b00)      r = 6'b001100;
      else if (ir[7:6] == 2'b01) r = 6'b000001;
      else if (ir[7:6] == 2'b10) r = {1'b0, ir[2], 4'b1100};
      else if (ir == 8'hC0)      r = 6'b000011;
      else if (ir == 8'hFF)      r = 6'b100000;
      return r;
   endfunction

   function automatic logic [5:0] outs();
      return {halt, op, selA, loadA, selB, loadB};
   endfunction

   task automatic drive(input logic [7:0] ir, input logic [5:0] exp_v);
      @(negedge clk);
      IR = ir;
      exp_q.push_back(exp_v);
   endtask

   task automatic sample(input string tag);
      logic [5:0] e;
      #2;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 8'd1, 8'd0);
      end else begin
         e = exp_q.pop_front();
         check(tag, {2'b00, outs()}, {2'b00, e});
      end
      check({tag, "_inv_halt_load"}, {7'd0, halt & (loadA | loadB)}, 8'd0);
      check({tag, "_inv_both_load"}, {7'd0, loadA & loadB}, 8'd0);
   endtask

   typedef struct {
      string      tag;
      logic [7:0] ir;
      logic [5:0] exp_v;
   } vec_t;

   vec_t vecs[$];

   initial begin
      n_checks = 0;
      n_errors = 0;
      clr = 1'b1;
      IR  = 8'h00;

      // IR cleared to 0 must decode as LDA 0.
      repeat (2) @(posedge clk);
      #1;
      check("reset_lda0", {2'b00, outs()}, 8'b0000_1100);
      @(negedge clk);
      clr = 1'b0;

      vecs.push_back('{"lda5",   8'h05, 6'b001100});
      vecs.push_back('{"ldb43",  8'h6B, 6'b000001});
      vecs.push_back('{"add",    8'h84, 6'b011100});
      vecs.push_back('{"sub",    8'h80, 6'b001100});
      vecs.push_back('{"mov",    8'hC0, 6'b000011});
      vecs.push_back('{"nop_c5", 8'hC5, 6'b000000});
      vecs.push_back('{"halt",   8'hFF, 6'b100000});
      vecs.push_back('{"nop_fe", 8'hFE, 6'b000000});
      vecs.push_back('{"alu_bf", 8'hBF, 6'b011100});
      vecs.push_back('{"alu_fb", 8'hFB, 6'b000000});
      vecs.push_back('{"ldb3f",  8'h7F, 6'b000001});
      vecs.push_back('{"lda3f",  8'h3F, 6'b001100});

      foreach (vecs[i]) begin
         drive(vecs[i].ir, vecs[i].exp_v);
         sample(vecs[i].tag);
      end

      // HALT then IR cleared with a clr pulse: halt must drop within 5 ns.
      drive(8'hFF, 6'b100000);
      sample("halt_pre");
      check("halt_pre_bit", {7'd0, halt}, 8'd1);
      @(negedge clk);
      IR  = 8'h00;
      clr = 1'b1;
      #4;
      check("halt_clr_drop", {7'd0, halt}, 8'd0);
      check("halt_clr_lda0", {2'b00, outs()}, 8'b0000_1100);
      #1;
      clr = 1'b0;

      // clr held high must not change a decode.
      @(negedge clk);
      clr = 1'b1;
      drive(8'h84, 6'b011100);
      sample("add_with_clr");
      clr = 1'b0;

      for (int v = 0; v < 256; v++) begin
         drive(v[7:0], ref_ctl(v[7:0]));
         sample($sformatf("sweep_%02h", v));
      end

      check("sb_drained", exp_q.size() == 0 ? 8'd0 : 8'd1, 8'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
